dispatch_scheduler: RTL

Converts a stream of timestamped input-spike events into the opcode packet stream consumed by `network_source`: RUN packets to advance network time, SPK packets to load inputs, and CLR packets to end an episode. Sits between the host-side event deserializer and `network_source`, driving its `src`/`src_valid` and honoring its `src_ready`. Tracks absolute network time, so the host sends only (time, index, charge) tuples.

---
 rtl/source_config_pkg.sv | 49 ++++
 rtl/dispatch_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/source_config_pkg.sv
// Shared network_source configuration: opcodes, packet layout, scheduler states
// and the packet packers used by both the encoder and the decoder side.
package source_config;

    localparam int NET_NUM_INP      = 4;
    localparam int NET_CHARGE_WIDTH = 8;
    localparam int IDX_WIDTH        = $clog2(NET_NUM_INP);
    localparam int OP_WIDTH         = 2;
    localparam int MAX_RUN_WIDTH    = 8;
    localparam int SPK_WIDTH        = IDX_WIDTH + NET_CHARGE_WIDTH;
    localparam int PAYLOAD_WIDTH    = (MAX_RUN_WIDTH > SPK_WIDTH) ? MAX_RUN_WIDTH : SPK_WIDTH;
    localparam int SRC_WIDTH        = OP_WIDTH + PAYLOAD_WIDTH;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP = 2'd0,
        OP_RUN = 2'd1,
        OP_SPK = 2'd2,
        OP_CLR = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SPIKE,
        S_TAIL,
        S_CLEAR
    } sched_state_t;

    // Count occupies the top run_width bits of the payload; run_width is a
    // constant at every call site so the shift folds away.
    function automatic logic [SRC_WIDTH-1:0] pack_run(input logic [MAX_RUN_WIDTH-1:0] count,
                                                      input int run_width);
        logic [PAYLOAD_WIDTH-1:0] field;
        field = PAYLOAD_WIDTH'(count) << (PAYLOAD_WIDTH - run_width);
        return {OP_RUN, field};
    endfunction

    function automatic logic [SRC_WIDTH-1:0] pack_spk(input logic [IDX_WIDTH-1:0] idx,
                                                      input logic signed [NET_CHARGE_WIDTH-1:0] val);
        logic [PAYLOAD_WIDTH-1:0] field;
        field = PAYLOAD_WIDTH'({idx, val}) << (PAYLOAD_WIDTH - SPK_WIDTH);
        return {OP_SPK, field};
    endfunction

    function automatic logic [SRC_WIDTH-1:0] pack_clr();
        return {OP_CLR, {PAYLOAD_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/dispatch_scheduler.sv
// Turns timestamped spike events into RUN/SPK/CLR packets for network_source,
// tracking absolute network time within an episode.
module dispatch_scheduler
    import source_config::*;
#(
    parameter int RUN_WIDTH   = 8,
    parameter int TIME_WIDTH  = 16,
    parameter bit CLR_ON_LAST = 1'b1
) (
    input  logic                               clk,
    input  logic                               arstn,
    input  logic                               evt_valid,
    output logic                               evt_ready,
    input  logic [TIME_WIDTH-1:0]              evt_time,
    input  logic [IDX_WIDTH-1:0]               evt_idx,
    input  logic signed [NET_CHARGE_WIDTH-1:0] evt_val,
    input  logic                               evt_last,
    input  logic [RUN_WIDTH-1:0]               run_tail,
    output logic                               src_valid,
    input  logic                               src_ready,
    output logic [SRC_WIDTH-1:0]               src,
    output logic [TIME_WIDTH-1:0]              cur_time,
    output logic                               late,
    output logic                               busy
);

    localparam logic [TIME_WIDTH-1:0] RUN_MAX = TIME_WIDTH'((1 << RUN_WIDTH) - 1);

    sched_state_t                      state, state_n;
    logic [TIME_WIDTH-1:0]             cur_time_n;
    logic                              late_n;
    logic [TIME_WIDTH-1:0]             ev_time, ev_time_n;
    logic [IDX_WIDTH-1:0]              ev_idx, ev_idx_n;
    logic signed [NET_CHARGE_WIDTH-1:0] ev_val, ev_val_n;
    logic                              ev_last, ev_last_n;
    logic [RUN_WIDTH-1:0]              ev_tail, ev_tail_n;
    logic [TIME_WIDTH-1:0]             gap_rem, gap_rem_n;
    logic [RUN_WIDTH-1:0]              chunk, chunk_n;
    logic [SRC_WIDTH-1:0]              src_n;
    logic                              hs;
    logic                              finish;

    assign hs        = src_valid && src_ready;
    assign evt_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Chunk for the RUN now on the bus, and for the one loaded at this edge.
    always_comb begin
        gap_rem   = ev_time - cur_time;
        chunk     = (gap_rem > RUN_MAX) ? RUN_MAX[RUN_WIDTH-1:0] : gap_rem[RUN_WIDTH-1:0];
        gap_rem_n = ev_time_n - cur_time_n;
        chunk_n   = (gap_rem_n > RUN_MAX) ? RUN_MAX[RUN_WIDTH-1:0] : gap_rem_n[RUN_WIDTH-1:0];
    end

    always_comb begin
        state_n    = state;
        cur_time_n = cur_time;
        late_n     = late;
        ev_time_n  = ev_time;
        ev_idx_n   = ev_idx;
        ev_val_n   = ev_val;
        ev_last_n  = ev_last;
        ev_tail_n  = ev_tail;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (evt_valid) begin
                    ev_time_n = evt_time;
                    ev_idx_n  = evt_idx;
                    ev_val_n  = evt_val;
                    ev_last_n = evt_last;
                    ev_tail_n = run_tail;
                    state_n   = (evt_time > cur_time) ? S_GAP : S_SPIKE;
                    if (evt_time < cur_time) late_n = 1'b1;
                end
            end
            S_GAP: begin
                if (hs) begin
                    cur_time_n = cur_time + TIME_WIDTH'(chunk);
                    if (cur_time_n == ev_time) state_n = S_SPIKE;
                end
            end
            S_SPIKE: begin
                if (hs) begin
                    if (!ev_last)            state_n = S_IDLE;
                    else if (ev_tail != '0)  state_n = S_TAIL;
                    else if (CLR_ON_LAST)    state_n = S_CLEAR;
                    else                     finish  = 1'b1;
                end
            end
            S_TAIL: begin
                if (hs) begin
                    if (CLR_ON_LAST) state_n = S_CLEAR;
                    else             finish  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (hs) finish = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // The tail is never added to cur_time; finishing zeroes it anyway.
        if (finish) begin
            state_n    = S_IDLE;
            cur_time_n = '0;
        end
    end

    // Packet for the state entered at this edge; while stalled the inputs are
    // unchanged, so the recomputed packet is bit-identical.
    always_comb begin
        case (state_n)
            S_GAP:   src_n = pack_run(MAX_RUN_WIDTH'(chunk_n), RUN_WIDTH);
            S_SPIKE: src_n = pack_spk(ev_idx_n, ev_val_n);
            S_TAIL:  src_n = pack_run(MAX_RUN_WIDTH'(ev_tail_n), RUN_WIDTH);
            S_CLEAR: src_n = pack_clr();
            default: src_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= S_IDLE;
            cur_time  <= '0;
            late      <= 1'b0;
            src       <= '0;
            src_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cur_time  <= cur_time_n;
            late      <= late_n;
            src       <= src_n;
            src_valid <= (state_n != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        ev_time <= ev_time_n;
        ev_idx  <= ev_idx_n;
        ev_val  <= ev_val_n;
        ev_last <= ev_last_n;
        ev_tail <= ev_tail_n;
    end

endmodule
